// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
// Shared constants and types for the sc1 instruction fetch stage.
//   ADDR_W_DEF / DATA_W_DEF : default PC/ROM-address and instruction widths
//   RESET_PC_DEF            : first fetch address after reset
//   NOP_INST                : sc1 NOP encoding
//   fetch_word_t            : (pc, instruction) pair at the default widths
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package inst_fetch_pkg;
   localparam int          ADDR_W_DEF   = 8;
   localparam int          DATA_W_DEF   = 32;
   localparam logic [7:0]  RESET_PC_DEF = 8'h00;
   localparam logic [31:0] NOP_INST     = 32'h0000_0001;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] pc;
      logic [DATA_W_DEF-1:0] word;
   } fetch_word_t;
endpackage

// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// Fetch -> decode handshake.
//   inst_valid : fetch holds a valid instruction
//   inst_ready : decode accepts when inst_valid && inst_ready at a clock edge
//   inst       : instruction word
//   inst_pc    : address of inst
// Modports: master (fetch side), slave (decode side).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface inst_fetch_if
   import inst_fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              inst_valid;
   logic              inst_ready;
   logic [DATA_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;

   modport master (output inst_valid, output inst, output inst_pc, input inst_ready);
   modport slave  (input inst_valid, input inst, input inst_pc, output inst_ready);
endinterface

// File: rtl/inst_fetch_skid.sv
// ---------------------------------------------------------------------------
// fetch_skid
// Output register plus a 1-entry skid register. Words arriving while the
// output register is stalled park in the skid, so back-pressure never drops
// or duplicates a word.
//   clk, reset_n          : clock, asynchronous active-low reset
//   flush                 : discard both registers (taken branch)
//   in_valid/in_data/in_pc: word returning from the ROM this cycle
//   out_ready             : downstream accepts
//   out_valid/out_data/out_pc : output register
//   skid_valid            : skid register occupied
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module fetch_skid
   import inst_fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_pc,
   output logic              skid_valid
);
   logic [DATA_W-1:0] skid_data_reg;
   logic [ADDR_W-1:0] skid_pc_reg;
   logic              load_slot;

   // Output register may take a new word when empty or being consumed.
   assign load_slot = !out_valid || out_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_pc        <= '0;
         skid_valid    <= 1'b0;
         skid_data_reg <= '0;
         skid_pc_reg   <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         if (load_slot) begin
            // The skid always holds the older word, so it drains first.
            if (skid_valid) begin
               out_valid  <= 1'b1;
               out_data   <= skid_data_reg;
               out_pc     <= skid_pc_reg;
               skid_valid <= 1'b0;
            end else if (in_valid) begin
               out_valid <= 1'b1;
               out_data  <= in_data;
               out_pc    <= in_pc;
            end else begin
               out_valid <= 1'b0;
            end
         end
         // A returning ROM word that did not reach the output register parks
         // here; the fetch issue rule keeps the skid free whenever this fires
         // (or frees it in the same cycle by draining it to the output).
         if (in_valid && (!load_slot || skid_valid)) begin
            skid_valid    <= 1'b1;
            skid_data_reg <= in_data;
            skid_pc_reg   <= in_pc;
         end
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// sc1 instruction fetch stage in front of a synchronous (1-cycle latency)
// instruction ROM. Tracks the PC and the outstanding ROM read, and hands
// words to decode through fetch_skid.
//   clk, reset_n   : clock, asynchronous active-low reset
//   run            : fetch enable; 0 stops new ROM reads, buffered words drain
//   rom_addr       : ROM address (registered, equals pc)
//   rom_data       : ROM output, valid the cycle after rom_addr is sampled
//   redirect_valid : taken branch pulse; flushes everything in flight
//   redirect_pc    : branch target
//   dec            : decode handshake (inst_valid/inst_ready/inst/inst_pc)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int              ADDR_W   = ADDR_W_DEF,
   parameter int              DATA_W   = DATA_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   inst_fetch_if.master      dec
);
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] inflight_pc_reg;
   logic              inflight_reg;
   logic              skid_valid;
   logic              out_valid;
   logic              issue;

   // A new read is only started when its data is guaranteed a home: either
   // the skid is empty and the output register is not stalled on a word that
   // is still returning from the ROM.
   assign issue = run && !redirect_valid && !skid_valid
                  && !(out_valid && !dec.inst_ready && inflight_reg);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_reg          <= RESET_PC;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
      end else if (redirect_valid) begin
         pc_reg       <= redirect_pc;
         inflight_reg <= 1'b0;
      end else if (issue) begin
         inflight_reg    <= 1'b1;
         inflight_pc_reg <= pc_reg;
         pc_reg          <= pc_reg + ADDR_W'(1);   // wraps modulo 2^ADDR_W
      end else begin
         inflight_reg <= 1'b0;
      end
   end

   assign rom_addr       = pc_reg;
   assign dec.inst_valid = out_valid;

   fetch_skid #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_skid (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (redirect_valid),
      .in_valid   (inflight_reg),
      .in_data    (rom_data),
      .in_pc      (inflight_pc_reg),
      .out_ready  (dec.inst_ready),
      .out_valid  (out_valid),
      .out_data   (dec.inst),
      .out_pc     (dec.inst_pc),
      .skid_valid (skid_valid)
   );
endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Directed + random bench for inst_fetch with a synchronous ROM model and a
// scoreboard of expected (pc, word) pairs, refilled on reset and redirect.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam int AW = ADDR_W_DEF;
   localparam int DW = DATA_W_DEF;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          run = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;

   inst_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) dif ();

   inst_fetch #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .RESET_PC (RESET_PC_DEF)
   ) u_dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .run            (run),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec            (dif)
   );

   always #5 clk = ~clk;

   // Program image
   function automatic logic [31:0] rom_word(input logic [7:0] a);
      case (a)
         8'h00:   return NOP_INST;
         8'h02:   return 32'h2000_0040;
         8'h24:   return 32'h0080_090c;
         default: return {8'hC3, a, a ^ 8'h5A, ~a};
      endcase
   endfunction

   logic [DW-1:0] rom_mem [0:255];
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   fetch_word_t exp_q[$];
   int checks = 0;
   int errors = 0;
   int accepts = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected stream after a reset or redirect: consecutive addresses.
   task automatic push_stream(input logic [7:0] start);
      logic [7:0] a;
      exp_q.delete();
      for (int i = 0; i < 1024; i++) begin
         a = start + 8'(i);
         exp_q.push_back(fetch_word_t'{pc: a, word: rom_word(a)});
      end
   endtask

   // Called just after a falling edge with inputs set: score the handshake
   // that the coming rising edge completes, then advance one cycle.
   task automatic step();
      fetch_word_t e;
      if (reset_n && dif.inst_valid && dif.inst_ready) begin
         accepts++;
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL sb_empty observed_pc=%h expected=nonempty", dif.inst_pc);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", 32'(dif.inst_pc), 32'(e.pc));
            chk("sb_inst", dif.inst, e.word);
         end
      end
      if (reset_n && redirect_valid) push_stream(redirect_pc);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom_mem[i] = rom_word(8'(i));
      dif.inst_ready = 1'b1;
      run            = 1'b1;
      reset_n        = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_valid", 32'(dif.inst_valid), 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'(RESET_PC_DEF));
      chk("rst_inst", dif.inst, 32'd0);
      chk("rst_inst_pc", 32'(dif.inst_pc), 32'd0);

      // 1: startup latency and first words
      push_stream(RESET_PC_DEF);
      reset_n = 1'b1;
      step();
      chk("lat_edge1_valid", 32'(dif.inst_valid), 32'd0);
      step();
      chk("lat_edge2_valid", 32'(dif.inst_valid), 32'd1);
      chk("lat_edge2_pc", 32'(dif.inst_pc), 32'(RESET_PC_DEF));
      chk("lat_edge2_inst", dif.inst, 32'h0000_0001);
      step();
      step();
      chk("word2_pc", 32'(dif.inst_pc), 32'h02);
      chk("word2_inst", dif.inst, 32'h2000_0040);

      // 2: stall; output holds, word 3 parks in skid, pc stops at 4
      dif.inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", 32'(dif.inst_valid), 32'd1);
         chk("stall_pc", 32'(dif.inst_pc), 32'h02);
         chk("stall_rom_addr", 32'(rom_addr), 32'h04);
      end

      // 3: redirect while stalled with a full skid
      redirect_valid = 1'b1;
      redirect_pc    = 8'h24;
      step();
      redirect_valid = 1'b0;
      dif.inst_ready = 1'b1;
      chk("redir_r0_valid", 32'(dif.inst_valid), 32'd0);
      step();
      chk("redir_r1_valid", 32'(dif.inst_valid), 32'd0);
      step();
      chk("redir_r2_valid", 32'(dif.inst_valid), 32'd1);
      chk("redir_r2_pc", 32'(dif.inst_pc), 32'h24);
      chk("redir_r2_inst", dif.inst, 32'h0080_090c);
      repeat (4) step();

      // 4: PC wrap
      redirect_valid = 1'b1;
      redirect_pc    = 8'hFE;
      step();
      redirect_valid = 1'b0;
      step();
      step();
      chk("wrap_fe", 32'(dif.inst_pc), 32'hFE);
      step();
      chk("wrap_ff", 32'(dif.inst_pc), 32'hFF);
      step();
      chk("wrap_00", 32'(dif.inst_pc), 32'h00);
      step();
      chk("wrap_01", 32'(dif.inst_pc), 32'h01);

      // run gate: word 02 already inflight still lands, pc holds at 03
      run = 1'b0;
      repeat (4) step();
      chk("halt_valid", 32'(dif.inst_valid), 32'd0);
      chk("halt_rom_addr", 32'(rom_addr), 32'h03);
      run = 1'b1;
      repeat (4) step();

      // 5: random ready / run / redirects
      for (int i = 0; i < 1000; i++) begin
         dif.inst_ready = 1'($urandom_range(0, 1));
         run            = ($urandom_range(0, 9) != 0);
         redirect_valid = ($urandom_range(0, 31) == 0);
         redirect_pc    = 8'($urandom_range(0, 255));
         step();
      end
      redirect_valid = 1'b0;
      run            = 1'b1;
      dif.inst_ready = 1'b1;
      repeat (6) step();
      checks++;
      assert (accepts > 200) else begin
         errors++;
         $error("FAIL rand_progress observed=%0d expected=>200", accepts);
      end

      // 6: asynchronous reset between edges
      chk("arst_pre_valid", 32'(dif.inst_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(dif.inst_valid), 32'd0);
      chk("arst_rom_addr", 32'(rom_addr), 32'(RESET_PC_DEF));
      @(negedge clk);
      push_stream(RESET_PC_DEF);
      reset_n = 1'b1;
      step();
      chk("arst_edge1_valid", 32'(dif.inst_valid), 32'd0);
      step();
      chk("arst_edge2_valid", 32'(dif.inst_valid), 32'd1);
      chk("arst_edge2_pc", 32'(dif.inst_pc), 32'(RESET_PC_DEF));
      chk("arst_edge2_inst", dif.inst, NOP_INST);
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage for the sc1 CPU, sitting directly upstream of the 256x32 synchronous instruction ROM and downstream of nothing but branch/redirect control.
- Drives the ROM address, tracks the ROM's one-cycle read latency and presents fetched words to decode via a valid/ready handshake.
- Includes a 1-entry skid buffer, so decode back-pressure never loses or duplicates an instruction.
- Supports taken-branch redirect with flush and a run/halt gate.

Parameters:
- ADDR_W, 8, ROM address / PC width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  fetch enable; 0 stops new ROM reads, buffered words still drain.
- rom_addr  out  ADDR_W  address to ROM; registered (equals pc).
- rom_data  in  DATA_W  ROM output; valid the cycle after the ROM samples rom_addr.
- redirect_valid  in  1  branch taken, one cycle pulse.
- redirect_pc  in  ADDR_W  branch target.
- inst_valid  out  1  inst/inst_pc hold a valid instruction.
- inst_ready  in  1  decode accepts when inst_valid && inst_ready at a clock edge.
- inst  out  DATA_W  instruction word.
- inst_pc  out  ADDR_W  address of inst.

Behaviour:
- Reset (async, reset_n low):
  - pc=RESET_PC.
  - inflight=0, skid_valid=0, inst_valid=0.
  - inst=0, inst_pc=0, rom_addr=RESET_PC.
- State:
  - pc is the ROM address.
  - inflight: ROM sampled pc at the previous edge, so rom_data is meaningful; inflight_pc records that address.
  - Output register (inst_valid/inst/inst_pc).
  - Skid register (skid_valid/skid_inst/skid_pc).
- Issue condition at an edge: run && !redirect_valid && !skid_valid && !(inst_valid && !inst_ready && inflight).
  - On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1, wrapping modulo 2^ADDR_W (0xFF -> 0x00).
  - Otherwise: inflight<=0, pc held.
- Accept = inst_valid && inst_ready.
- Data movement each edge, in this priority:
  - (a) If output register is empty or accepted:
    - Load from skid if skid_valid (skid_valid<=0).
    - Else load from rom_data/inflight_pc if inflight.
    - Else inst_valid<=0.
  - (b) If inflight and the ROM word was not loaded into the output register, write it to the skid register (skid_valid<=1).
    - The issue condition guarantees the skid is free whenever this happens.
- Ordering: instructions leave strictly in address order; no word is duplicated or dropped under any ready pattern.
- Redirect (redirect_valid=1 at an edge), overrides everything:
  - pc<=redirect_pc, inflight<=0, skid_valid<=0, inst_valid<=0.
  - A same-cycle accept is still consumed by decode (decode owns that instruction).
  - First target instruction: ROM reads redirect_pc at edge+1; inst_valid at edge+2.
- Latency: from reset release with run=1, inst_valid rises after the 2nd clock edge with inst_pc=RESET_PC. Steady state is 1 inst/cycle with inst_ready=1.
- run falling: no further issue; an already inflight word still lands. run rising resumes at the current pc.
- Reset asserted mid-operation clears all state asynchronously; no partial output.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, RESET_PC, and the NOP encoding (32'h00000001) for bench comparisons.
- One natural sub-module: fetch_skid (1-entry skid/output register pair with valid/ready), holding the priority rules (a)/(b).
- The PC/inflight logic stays in inst_fetch.

Test Plan:
1. Reset release, run=1, inst_ready=1, ROM model of program image → inst_valid after edge 2; inst_pc 0x00,0x01,0x02… consecutive; inst matches ROM (0x00→0x00000001, 0x02→0x20000040).
2. Hold inst_ready=0 for 5 cycles after first valid → inst/inst_pc stable at 0x00; at most one word in skid; pc stops advancing; on release, sequence continues 0x01,0x02 with no gap/duplicate.
3. redirect_valid with redirect_pc=0x24 while skid full and inflight → next valid instruction is 0x24 (0x0080090c) exactly 2 edges later; no stale 0x0x words after redirect.
4. redirect to 0xFE, continuous ready → inst_pc 0xFE,0xFF,0x00,0x01 (wrap).
5. Random inst_ready (50%) over 1000 cycles plus random redirects → scoreboard: address-ordered, complete, unique output vs reference PC model.
6. reset_n pulsed low mid-stream (asynchronous, between edges) → inst_valid=0 immediately; after release, fetch restarts at RESET_PC with 2-edge latency.
